// File: rtl/signal_history_recall_if.sv
// signal_history_recall_if: request/response bundle of the ValueFind recall port
interface signal_history_recall_if #(parameter int TSW = 1);
  logic [TSW-1:0] tracked_signal;
  logic signed [31:0] cycles_back_to_recall;
  logic recalculate_back_cycle;
  logic [TSW-1:0] signal_recall;
  logic data_valid;
  logic recall_out_of_range;
  logic history_full;
  modport master (
    output tracked_signal, cycles_back_to_recall, recalculate_back_cycle,
    input signal_recall, data_valid, recall_out_of_range, history_full
  );
  modport slave (
    input tracked_signal, cycles_back_to_recall, recalculate_back_cycle,
    output signal_recall, data_valid, recall_out_of_range, history_full
  );
endinterface

// File: rtl/signal_history_recall.sv
// signal_history_recall: circular history of a tracked signal with 1-cycle recall of past values
module signal_history_recall #(
  parameter int TRACKED_SIGNAL_WIDTH = 1,
  parameter int HISTORY_DEPTH = 64
) (
  input logic clk,
  input logic rst,
  signal_history_recall_if.slave bus
);
  localparam int AW = $clog2(HISTORY_DEPTH);
  localparam logic [AW:0] DEPTH_F = (AW+1)'(HISTORY_DEPTH);
  typedef enum logic {FILLING, FULL} state_t;
  state_t state, state_nx;
  logic [TRACKED_SIGNAL_WIDTH-1:0] mem [HISTORY_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0] fill;
  logic [31:0] n;
  logic oor;
  logic [TRACKED_SIGNAL_WIDTH-1:0] rd_val;
  logic [TRACKED_SIGNAL_WIDTH-1:0] recall_q;
  logic valid_q;
  logic oor_q;
  assign n = bus.cycles_back_to_recall;
  // Next state and recall lookup; read uses the pre-write pointer so the current sample only comes via bypass
  always_comb begin
    state_nx = (state == FILLING && fill >= DEPTH_F - 1'b1) ? FULL : state;
    oor = n[31] || ($signed(n) > $signed(32'(fill)));
    rd_val = (n == 32'd0) ? bus.tracked_signal
           : oor ? '0 : mem[wr_ptr - n[AW-1:0]];
  end
  // Sample capture every non-reset cycle
  always_ff @(posedge clk)
    if (!rst) mem[wr_ptr] <= bus.tracked_signal;
  // State register, pointers and registered response
  always_ff @(posedge clk)
    if (rst) begin
      state <= FILLING;
      wr_ptr <= '0;
      fill <= '0;
      recall_q <= '0;
      valid_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      state <= state_nx;
      wr_ptr <= wr_ptr + 1'b1;
      fill <= (fill == DEPTH_F) ? fill : fill + 1'b1;
      valid_q <= bus.recalculate_back_cycle;
      oor_q <= bus.recalculate_back_cycle && oor;
      if (bus.recalculate_back_cycle) recall_q <= rd_val;
    end
  assign bus.signal_recall = recall_q;
  assign bus.data_valid = valid_q;
  assign bus.recall_out_of_range = oor_q;
  assign bus.history_full = (state == FULL);
endmodule

// File: tb/tb_signal_history_recall.sv
// tb_signal_history_recall: randomized scoreboard bench against a queue-based history model
module tb_signal_history_recall;
  localparam int TSW = 8;
  localparam int DEPTH = 64;
  typedef struct {
    int due;
    logic v;
    logic [TSW-1:0] val;
    logic oor;
    logic full;
  } exp_t;
  logic clk;
  logic rst;
  int cyc;
  int tests;
  int fails;
  exp_t sb[$];
  logic [TSW-1:0] hist[$];
  logic [TSW-1:0] last_recall;
  signal_history_recall_if #(.TSW(TSW)) bus();
  signal_history_recall #(.TRACKED_SIGNAL_WIDTH(TSW), .HISTORY_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  // Drive one cycle of stimulus and push the response the model expects after the coming edge
  task automatic tick(input logic r, input logic [TSW-1:0] ts, input logic req, input int n);
    exp_t e;
    int f;
    rst = r;
    bus.tracked_signal = ts;
    bus.recalculate_back_cycle = req;
    bus.cycles_back_to_recall = n;
    e.due = cyc + 1;
    e.v = 1'b0;
    e.oor = 1'b0;
    if (r) begin
      hist.delete();
      last_recall = '0;
    end else begin
      if (req) begin
        f = hist.size();
        e.v = 1'b1;
        if (n == 0) last_recall = ts;
        else if (n < 0 || n > f) begin
          last_recall = '0;
          e.oor = 1'b1;
        end else last_recall = hist[f-n];
      end
      hist.push_back(ts);
      if (hist.size() > DEPTH) void'(hist.pop_front());
    end
    e.val = last_recall;
    e.full = (hist.size() == DEPTH);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  // Monitor: compare every presented cycle against the scoreboard entry due now
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("data_valid", 32'(bus.data_valid), 32'(e.v));
      chk("out_of_range", 32'(bus.recall_out_of_range), 32'(e.oor));
      chk("signal_recall", 32'(bus.signal_recall), 32'(e.val));
      chk("history_full", 32'(bus.history_full), 32'(e.full));
    end
  end
  initial begin
    tests = 0;
    fails = 0;
    last_recall = '0;
    tick(1, 0, 0, 0);
    for (int t = 0; t <= 30; t++) tick(0, TSW'(t), t == 10 || t == 20, t == 10 ? 3 : 0);
    tick(1, 0, 0, 0);
    tick(0, 8'h11, 0, 0);
    tick(0, 8'h22, 0, 0);
    tick(0, 8'h33, 1, 5);
    tick(0, 8'h44, 1, -1);
    tick(0, 8'h55, 1, 65);
    tick(0, 8'h66, 1, 2);
    tick(1, 0, 0, 0);
    for (int t = 0; t <= 205; t++)
      tick(0, TSW'(t), (t >= 100 && t <= 110) || t == 200 || t == 64 || t == 63,
           t == 200 ? 64 : (t >= 100 && t <= 110) ? 1 : t);
    tick(0, 8'hA5, 1, 1);
    tick(1, 8'h50, 1, 1);
    tick(1, 8'h51, 1, 1);
    tick(0, 8'h52, 1, 1);
    tick(0, 8'h53, 1, 1);
    tick(0, 8'h54, 1, 0);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 199) == 0, TSW'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0 ? int'($urandom) : int'($urandom_range(0, 70)) - 2);
    tick(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
